// File: rtl/nts_tx_pkg.sv
// Shared definitions for the NTS TX scheduler: FSM state encoding, field widths, index-width helper.
// Pure declarations; no logic, no latency, no flow control.
package nts_tx_pkg;

  localparam int LAST_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_START   = 2'd1,
    ST_STREAM  = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  function automatic int grant_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nts_rr_arbiter.sv
// Round-robin pick: first requester after ptr (wrapping), combinational, zero latency.
// No flow control; found=0 when no request is pending.
module nts_rr_arbiter
  import nts_tx_pkg::*;
#(
  parameter int ENGINES = 18,
  localparam int GW = grant_width(ENGINES)
) (
  input  logic [ENGINES-1:0] req,
  input  logic [GW-1:0]      ptr,
  output logic [GW-1:0]      grant,
  output logic               found
);

  logic [GW-1:0] idx;

  always_comb begin
    found = 1'b0;
    grant = '0;
    idx   = '0;
    for (int i = 1; i <= ENGINES; i++) begin
      idx = GW'((int'(ptr) + i) % ENGINES);
      if (!found && req[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
  end

endmodule

// File: rtl/nts_tx_scheduler.sv
// Round-robin engine TX scheduler: grant, stream through a 1-word hold (2-cycle latency), release, watchdog abort.
// No backpressure mid-packet; i_enable and i_buffer_ready only gate new grants in IDLE.
module nts_tx_scheduler
  import nts_tx_pkg::*;
#(
  parameter int ENGINES         = 18,
  parameter int MAC_DATA_WIDTH  = 64,
  parameter int LAST_WIDTH      = nts_tx_pkg::LAST_WIDTH,
  parameter int WATCHDOG_CYCLES = 1024,
  localparam int GW = grant_width(ENGINES)
) (
  input  logic                              i_clk,
  input  logic                              i_areset,
  input  logic                              i_enable,
  input  logic                              i_buffer_ready,
  input  logic [ENGINES-1:0]                i_engine_packet_available,
  input  logic [ENGINES-1:0]                i_engine_fifo_empty,
  input  logic [ENGINES-1:0]                i_engine_fifo_rd_valid,
  input  logic [MAC_DATA_WIDTH*ENGINES-1:0] i_engine_fifo_rd_data,
  input  logic [LAST_WIDTH*ENGINES-1:0]     i_engine_bytes_last_word,
  output logic [ENGINES-1:0]                o_engine_fifo_rd_start,
  output logic [ENGINES-1:0]                o_engine_packet_read,
  output logic                              o_tx_valid,
  output logic [MAC_DATA_WIDTH-1:0]         o_tx_data,
  output logic                              o_tx_last,
  output logic [LAST_WIDTH-1:0]             o_tx_bytes,
  output logic                              o_tx_abort,
  output logic                              o_busy,
  output logic [GW-1:0]                     o_grant,
  output logic [31:0]                       o_packets,
  output logic [31:0]                       o_aborts
);

  localparam int WDW = $clog2(WATCHDOG_CYCLES + 1);

  state_t                    state_q, state_d;
  logic [GW-1:0]             grant_q, grant_d;
  logic [GW-1:0]             ptr_q, ptr_d;
  logic [MAC_DATA_WIDTH-1:0] hold_q, hold_d;
  logic                      hold_full_q, hold_full_d;
  logic [WDW-1:0]            wd_q, wd_d;
  logic                      aborted_q, aborted_d;

  logic [ENGINES-1:0]        rd_start_d, pkt_read_d;
  logic                      tx_valid_d, tx_last_d, tx_abort_d;
  logic [MAC_DATA_WIDTH-1:0] tx_data_d;
  logic [LAST_WIDTH-1:0]     tx_bytes_d;
  logic [31:0]               packets_d, aborts_d;

  logic [GW-1:0]             arb_grant;
  logic                      arb_found;

  logic [MAC_DATA_WIDTH-1:0] eng_data  [ENGINES];
  logic [LAST_WIDTH-1:0]     eng_bytes [ENGINES];

  for (genvar g = 0; g < ENGINES; g++) begin : g_unpack
    assign eng_data[g]  = i_engine_fifo_rd_data[g*MAC_DATA_WIDTH +: MAC_DATA_WIDTH];
    assign eng_bytes[g] = i_engine_bytes_last_word[g*LAST_WIDTH +: LAST_WIDTH];
  end

  nts_rr_arbiter #(.ENGINES(ENGINES)) u_arb (
    .req   (i_engine_packet_available),
    .ptr   (ptr_q),
    .grant (arb_grant),
    .found (arb_found)
  );

  // Only the registered grant steers the data path; other engines are ignored.
  logic                      sel_valid, sel_empty;
  logic [MAC_DATA_WIDTH-1:0] sel_data;
  logic [LAST_WIDTH-1:0]     sel_bytes;
  assign sel_valid = i_engine_fifo_rd_valid[grant_q];
  assign sel_empty = i_engine_fifo_empty[grant_q];
  assign sel_data  = eng_data[grant_q];
  assign sel_bytes = eng_bytes[grant_q];

  assign o_busy  = (state_q != ST_IDLE);
  assign o_grant = grant_q;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    ptr_d       = ptr_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    wd_d        = wd_q;
    aborted_d   = aborted_q;
    packets_d   = o_packets;
    aborts_d    = o_aborts;
    rd_start_d  = '0;
    pkt_read_d  = '0;
    tx_valid_d  = 1'b0;
    tx_last_d   = 1'b0;
    tx_bytes_d  = '0;
    tx_abort_d  = 1'b0;
    tx_data_d   = o_tx_data;
    case (state_q)
      ST_IDLE: begin
        // The release pulse cycle is skipped so the engine can drop packet_available.
        if (i_enable && i_buffer_ready && arb_found && (o_engine_packet_read == '0)) begin
          grant_d               = arb_grant;
          rd_start_d[arb_grant] = 1'b1;
          state_d               = ST_START;
        end
      end
      ST_START: begin
        wd_d        = '0;
        hold_full_d = 1'b0;
        aborted_d   = 1'b0;
        state_d     = ST_STREAM;
      end
      ST_STREAM: begin
        if (sel_valid) begin
          wd_d = '0;
          if (hold_full_q) begin
            tx_valid_d = 1'b1;
            tx_data_d  = hold_q;
          end
          hold_d      = sel_data;
          hold_full_d = 1'b1;
        end else if (sel_empty) begin
          if (hold_full_q) begin
            tx_valid_d = 1'b1;
            tx_data_d  = hold_q;
            tx_last_d  = 1'b1;
            tx_bytes_d = sel_bytes;
          end else begin
            tx_abort_d = 1'b1;
            aborts_d   = o_aborts + 32'd1;
            aborted_d  = 1'b1;
          end
          hold_full_d = 1'b0;
          state_d     = ST_RELEASE;
        end else if (wd_q == WDW'(WATCHDOG_CYCLES - 1)) begin
          tx_abort_d  = 1'b1;
          aborts_d    = o_aborts + 32'd1;
          aborted_d   = 1'b1;
          hold_full_d = 1'b0;
          state_d     = ST_RELEASE;
        end else begin
          wd_d = wd_q + WDW'(1);
        end
      end
      ST_RELEASE: begin
        pkt_read_d[grant_q] = 1'b1;
        ptr_d               = grant_q;
        if (!aborted_q) packets_d = o_packets + 32'd1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) begin
      state_q                <= ST_IDLE;
      grant_q                <= '0;
      ptr_q                  <= GW'(ENGINES - 1);
      hold_q                 <= '0;
      hold_full_q            <= 1'b0;
      wd_q                   <= '0;
      aborted_q              <= 1'b0;
      o_engine_fifo_rd_start <= '0;
      o_engine_packet_read   <= '0;
      o_tx_valid             <= 1'b0;
      o_tx_data              <= '0;
      o_tx_last              <= 1'b0;
      o_tx_bytes             <= '0;
      o_tx_abort             <= 1'b0;
      o_packets              <= '0;
      o_aborts               <= '0;
    end else begin
      state_q                <= state_d;
      grant_q                <= grant_d;
      ptr_q                  <= ptr_d;
      hold_q                 <= hold_d;
      hold_full_q            <= hold_full_d;
      wd_q                   <= wd_d;
      aborted_q              <= aborted_d;
      o_engine_fifo_rd_start <= rd_start_d;
      o_engine_packet_read   <= pkt_read_d;
      o_tx_valid             <= tx_valid_d;
      o_tx_data              <= tx_data_d;
      o_tx_last              <= tx_last_d;
      o_tx_bytes             <= tx_bytes_d;
      o_tx_abort             <= tx_abort_d;
      o_packets              <= packets_d;
      o_aborts               <= aborts_d;
    end
  end

endmodule

// File: tb/tb_nts_tx_scheduler.sv
// Directed + randomized bench for nts_tx_scheduler with a queue-based engine/packet reference model.
module tb_nts_tx_scheduler;

  localparam int N  = 18;
  localparam int W  = 64;
  localparam int LW = 4;
  localparam int WD = 16;
  localparam int GW = $clog2(N);

  logic            clk = 1'b0;
  logic            arst;
  logic            enable, ready;
  logic [N-1:0]    avail, empty, rdv;
  logic [W*N-1:0]  rd_data;
  logic [LW*N-1:0] bl;
  logic [W-1:0]    dat_a [N];
  logic [LW-1:0]   byt_a [N];

  logic [N-1:0]    o_engine_fifo_rd_start, o_engine_packet_read;
  logic            o_tx_valid, o_tx_last, o_tx_abort, o_busy;
  logic [W-1:0]    o_tx_data;
  logic [LW-1:0]   o_tx_bytes;
  logic [GW-1:0]   o_grant;
  logic [31:0]     o_packets, o_aborts;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign rd_data[g*W +: W]  = dat_a[g];
    assign bl[g*LW +: LW]     = byt_a[g];
  end

  nts_tx_scheduler #(.ENGINES(N), .MAC_DATA_WIDTH(W), .LAST_WIDTH(LW), .WATCHDOG_CYCLES(WD)) dut (
    .i_clk                     (clk),
    .i_areset                  (arst),
    .i_enable                  (enable),
    .i_buffer_ready            (ready),
    .i_engine_packet_available (avail),
    .i_engine_fifo_empty       (empty),
    .i_engine_fifo_rd_valid    (rdv),
    .i_engine_fifo_rd_data     (rd_data),
    .i_engine_bytes_last_word  (bl),
    .o_engine_fifo_rd_start    (o_engine_fifo_rd_start),
    .o_engine_packet_read      (o_engine_packet_read),
    .o_tx_valid                (o_tx_valid),
    .o_tx_data                 (o_tx_data),
    .o_tx_last                 (o_tx_last),
    .o_tx_bytes                (o_tx_bytes),
    .o_tx_abort                (o_tx_abort),
    .o_busy                    (o_busy),
    .o_grant                   (o_grant),
    .o_packets                 (o_packets),
    .o_aborts                  (o_aborts)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [W-1:0]  d;
    logic          last;
    logic [LW-1:0] b;
    int            c;
  } txrec_t;

  txrec_t       tx_q[$];
  logic [W-1:0] sent[$];
  int           abort_cnt = 0;
  int           abort_cyc = -1;
  int           start_cnt = 0;
  int           exp_packets = 0;
  int           exp_aborts = 0;
  int           ptr = N - 1;

  always @(negedge clk) begin
    if (!arst) begin
      if (o_tx_valid) tx_q.push_back('{o_tx_data, o_tx_last, o_tx_bytes, cyc});
      if (o_tx_abort) begin
        abort_cnt++;
        abort_cyc = cyc;
      end
      if (o_engine_fifo_rd_start != '0) start_cnt++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] onehot(input int e);
    return N'(1) << e;
  endfunction

  function automatic int rr_next(input int p, input logic [N-1:0] m);
    logic [N-1:0] t;
    for (int k = 1; k <= N; k++) begin
      t = m >> ((p + k) % N);
      if (t[0]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int e, input logic v, input logic [W-1:0] d);
    for (int k = 0; k < N; k++) dat_a[k] = {$urandom, $urandom};
    dat_a[e] = d;
    rdv      = N'($urandom) & ~onehot(e);
    if (v) rdv = rdv | onehot(e);
  endtask

  task automatic wait_start(input int e, output int sc);
    int n = 0;
    while (o_engine_fifo_rd_start == '0 && n < 200) begin
      tick();
      n++;
    end
    check("start_seen", 64'(n < 200), 64'(1));
    check("rd_start_onehot", 64'(o_engine_fifo_rd_start), 64'(onehot(e)));
    check("grant", 64'(o_grant), 64'(e));
    sc = cyc;
    tick();
    check("rd_start_one_cycle", 64'(o_engine_fifo_rd_start), 64'(0));
  endtask

  task automatic stream(input int e, input int nw, input int nb, input int maxgap,
                        input bit stall, output int fc);
    int gap;
    logic [W-1:0] w;
    sent.delete();
    tx_q.delete();
    fc = -1;
    byt_a[e] = LW'(nb);
    for (int i = 0; i < nw; i++) begin
      gap = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
      repeat (gap) begin
        drive(e, 1'b0, '0);
        tick();
      end
      w = {$urandom, $urandom};
      sent.push_back(w);
      if (i == 0) fc = cyc;
      drive(e, 1'b1, w);
      tick();
    end
    drive(e, 1'b0, '0);
    if (!stall) empty[e] = 1'b1;
  endtask

  task automatic wait_release(input int e, input bit keep, output int rc);
    int n = 0;
    while (o_engine_packet_read == '0 && n < WD * 4 + 50) begin
      tick();
      n++;
    end
    check("release_seen", 64'(n < WD * 4 + 50), 64'(1));
    check("packet_read_onehot", 64'(o_engine_packet_read), 64'(onehot(e)));
    rc = cyc;
    ptr = e;
    if (keep) empty[e] = 1'b0;
    else begin
      avail[e] = 1'b0;
      empty[e] = 1'b1;
    end
  endtask

  task automatic check_packet(input int nb);
    check("tx_count", 64'(tx_q.size()), 64'(sent.size()));
    for (int i = 0; i < tx_q.size() && i < sent.size(); i++) begin
      check("tx_data", tx_q[i].d, sent[i]);
      check("tx_last", 64'(tx_q[i].last), 64'(i == sent.size() - 1));
      if (i == sent.size() - 1) check("tx_bytes", 64'(tx_q[i].b), 64'(nb));
    end
    exp_packets++;
    check("packets", 64'(o_packets), 64'(exp_packets));
    check("aborts_steady", 64'(o_aborts), 64'(exp_aborts));
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int sc, fc, rc, e, nw, nb, s0, c0;
    logic [N-1:0] mask;
    arst   = 1'b1;
    enable = 1'b1;
    ready  = 1'b1;
    avail  = '0;
    empty  = '1;
    rdv    = '0;
    for (int k = 0; k < N; k++) begin
      dat_a[k] = '0;
      byt_a[k] = '0;
    end
    repeat (3) tick();
    check("rst_busy", 64'(o_busy), 64'(0));
    check("rst_counters", {o_packets, o_aborts}, 64'(0));
    check("rst_pulses", 64'({o_engine_fifo_rd_start, o_engine_packet_read}), 64'(0));
    arst = 1'b0;
    tick();

    // 4-word back-to-back packet from engine 5
    avail[5] = 1'b1; empty[5] = 1'b0;
    wait_start(5, sc);
    stream(5, 4, 6, 0, 1'b0, fc);
    wait_release(5, 1'b0, rc);
    check_packet(6);
    if (tx_q.size() > 0) check("first_word_latency", 64'(tx_q[0].c - fc), 64'(2));

    // single-word packet from engine 3
    avail[3] = 1'b1; empty[3] = 1'b0;
    wait_start(3, sc);
    stream(3, 1, 8, 0, 1'b0, fc);
    wait_release(3, 1'b0, rc);
    check_packet(8);
    if (tx_q.size() > 0) check("release_after_last", 64'(rc - tx_q[0].c), 64'(1));

    // watchdog: two words then stall with FIFO not empty
    avail[11] = 1'b1; empty[11] = 1'b0;
    abort_cnt = 0;
    wait_start(11, sc);
    stream(11, 2, 5, 0, 1'b1, fc);
    wait_release(11, 1'b0, rc);
    exp_aborts++;
    check("wd_abort_cnt", 64'(abort_cnt), 64'(1));
    check("wd_abort_cycle", 64'(abort_cyc - (fc + 1)), 64'(WD + 1));
    check("wd_tx_count", 64'(tx_q.size()), 64'(1));
    if (tx_q.size() > 0) begin
      check("wd_no_last", 64'(tx_q[0].last), 64'(0));
      check("wd_first_word", tx_q[0].d, sent[0]);
    end
    check("wd_aborts", 64'(o_aborts), 64'(exp_aborts));
    check("wd_packets", 64'(o_packets), 64'(exp_packets));

    // empty packet counts as abort
    avail[2] = 1'b1; empty[2] = 1'b0;
    abort_cnt = 0;
    wait_start(2, sc);
    tx_q.delete();
    drive(2, 1'b0, '0);
    empty[2] = 1'b1;
    wait_release(2, 1'b0, rc);
    exp_aborts++;
    check("empty_abort_cnt", 64'(abort_cnt), 64'(1));
    check("empty_no_tx", 64'(tx_q.size()), 64'(0));
    check("empty_aborts", 64'(o_aborts), 64'(exp_aborts));
    check("empty_packets", 64'(o_packets), 64'(exp_packets));

    // buffer-ready gating, then enable drop mid-packet
    ready = 1'b0;
    avail[9] = 1'b1; empty[9] = 1'b0;
    s0 = start_cnt;
    repeat (6) tick();
    check("ready_gates_grant", 64'(start_cnt - s0), 64'(0));
    ready = 1'b1;
    c0 = cyc;
    wait_start(9, sc);
    check("ready_to_start", 64'(sc - c0), 64'(1));
    enable = 1'b0;
    ready  = 1'b0;
    avail[10] = 1'b1; empty[10] = 1'b0;
    stream(9, 3, 7, 2, 1'b0, fc);
    wait_release(9, 1'b0, rc);
    check_packet(7);
    s0 = start_cnt;
    ready = 1'b1;
    repeat (12) tick();
    check("enable_gates_grant", 64'(start_cnt - s0), 64'(0));
    enable = 1'b1;
    wait_start(rr_next(ptr, avail), sc);
    stream(10, 2, 3, 1, 1'b0, fc);
    wait_release(10, 1'b0, rc);
    check_packet(3);

    // randomized request masks served in round-robin order
    repeat (4) begin
      mask = (N'($urandom) & N'($urandom)) | onehot(int'($urandom_range(0, N - 1)));
      avail = mask;
      empty = ~mask;
      while (mask != '0) begin
        e  = rr_next(ptr, mask);
        nw = int'($urandom_range(1, 5));
        nb = int'($urandom_range(1, 8));
        wait_start(e, sc);
        stream(e, nw, nb, 3, 1'b0, fc);
        wait_release(e, 1'b0, rc);
        check_packet(nb);
        mask = mask & ~onehot(e);
      end
    end

    // asynchronous reset in the middle of a packet
    avail[7] = 1'b1; empty[7] = 1'b0;
    wait_start(7, sc);
    stream(7, 2, 4, 0, 1'b1, fc);
    check("pre_reset_busy", 64'(o_busy), 64'(1));
    arst = 1'b1;
    #1;
    check("arst_busy_grant", 64'({o_busy, o_grant}), 64'(0));
    check("arst_counters", {o_packets, o_aborts}, 64'(0));
    check("arst_tx", 64'({o_tx_valid, o_tx_last, o_tx_bytes, o_tx_abort}), 64'(0));
    check("arst_tx_data", o_tx_data, 64'(0));
    check("arst_pulses", 64'({o_engine_fifo_rd_start, o_engine_packet_read}), 64'(0));
    avail = '0; empty = '1; rdv = '0;
    exp_packets = 0; exp_aborts = 0; ptr = N - 1;
    tick();
    tick();
    arst = 1'b0;

    // all engines requesting: grants 0..17 then 0 again
    avail = '1;
    empty = '0;
    for (int k = 0; k <= N; k++) begin
      nb = int'($urandom_range(1, 8));
      wait_start(k % N, sc);
      stream(k % N, 1, nb, 0, 1'b0, fc);
      wait_release(k % N, 1'b1, rc);
      check_packet(nb);
    end
    avail = '0;
    empty = '1;
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
